// File: rtl/arb_pkg.sv
// Shared constants, state encoding and helpers for the round-robin arbiter.
package arb_pkg;

   localparam int N_REQ  = 8;
   localparam int IDX_W  = 3;
   localparam int HOLD_W = 8;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Index following idx, wrapping 7 -> 0 through the 3-bit width.
   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      return idx + 3'd1;
   endfunction

endpackage

// File: rtl/decoder_3_to_8.sv
// Enabled 3-to-8 one-hot decoder; all zeros while en is low.
module decoder_3_to_8 (
   input  logic [2:0] sel,
   input  logic       en,
   output logic [7:0] dec
);

   // One-hot decode of sel, gated by en.
   always_comb begin
      dec = 8'h00;
      if (en) begin
         case (sel)
            3'd0:    dec = 8'h01;
            3'd1:    dec = 8'h02;
            3'd2:    dec = 8'h04;
            3'd3:    dec = 8'h08;
            3'd4:    dec = 8'h10;
            3'd5:    dec = 8'h20;
            3'd6:    dec = 8'h40;
            3'd7:    dec = 8'h80;
            default: dec = 8'h00;
         endcase
      end else begin
         dec = 8'h00;
      end
   end

endmodule

// File: rtl/rr_pick_8.sv
// Rotated find-first: lowest set bit of req scanning ptr, ptr+1, ... mod 8.
module rr_pick_8
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic             found_s;
   logic [IDX_W-1:0] pos_s;

   assign any = |req;

   // Walk the request vector starting at ptr; the first hit wins.
   always_comb begin
      idx     = 3'd0;
      found_s = 1'b0;
      pos_s   = 3'd0;
      for (int k = 0; k < N_REQ; k++) begin
         pos_s = ptr + 3'(k);
         if (!found_s && req[pos_s]) begin
            idx     = pos_s;
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with grant hold and optional hold-limit
// preemption. One dead cycle always separates consecutive grants.
module rr_arbiter_8
   import arb_pkg::*;
#(
   parameter int HOLD_MAX = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             preempt
);

   // Last hold_cnt value a grant may reach before it is taken away.
   localparam logic [HOLD_W-1:0] HOLD_LAST = (HOLD_MAX == 0) ? 8'd0 : HOLD_W'(HOLD_MAX - 1);
   localparam logic [HOLD_W-1:0] HOLD_SAT  = 8'hFF;
   localparam logic              HOLD_ON   = (HOLD_MAX != 0) ? 1'b1 : 1'b0;

   arb_state_t        state_r,     state_s;
   logic [IDX_W-1:0]  ptr_r,       ptr_s;
   logic [HOLD_W-1:0] hold_cnt_r,  hold_cnt_s;
   logic [IDX_W-1:0]  gnt_idx_r,   gnt_idx_s;
   logic              gnt_valid_r, gnt_valid_s;
   logic              preempt_r,   preempt_s;

   logic [IDX_W-1:0]  pick_idx_s;
   logic              pick_any_s;

   rr_pick_8 u_pick (
      .req (req),
      .ptr (ptr_r),
      .idx (pick_idx_s),
      .any (pick_any_s)
   );

   // Next-state and next-output logic for the IDLE/GRANT machine.
   always_comb begin
      state_s     = state_r;
      ptr_s       = ptr_r;
      hold_cnt_s  = hold_cnt_r;
      gnt_idx_s   = gnt_idx_r;
      gnt_valid_s = gnt_valid_r;
      preempt_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (en && pick_any_s) begin
               state_s     = GRANT;
               gnt_idx_s   = pick_idx_s;
               gnt_valid_s = 1'b1;
               hold_cnt_s  = 8'd0;
            end else begin
               gnt_idx_s   = 3'd0;
               gnt_valid_s = 1'b0;
            end
         end
         GRANT: begin
            if (!req[gnt_idx_r]) begin
               // Release takes precedence over the hold limit.
               state_s     = IDLE;
               ptr_s       = next_idx(gnt_idx_r);
               gnt_idx_s   = 3'd0;
               gnt_valid_s = 1'b0;
               hold_cnt_s  = 8'd0;
            end else if (HOLD_ON && (hold_cnt_r == HOLD_LAST)) begin
               state_s     = IDLE;
               ptr_s       = next_idx(gnt_idx_r);
               gnt_idx_s   = 3'd0;
               gnt_valid_s = 1'b0;
               hold_cnt_s  = 8'd0;
               preempt_s   = 1'b1;
            end else begin
               hold_cnt_s  = (hold_cnt_r == HOLD_SAT) ? hold_cnt_r : hold_cnt_r + 8'd1;
            end
         end
         default: begin
            state_s     = IDLE;
            gnt_idx_s   = 3'd0;
            gnt_valid_s = 1'b0;
            hold_cnt_s  = 8'd0;
         end
      endcase
   end

   // State and output registers; reset clears the grant with no preempt pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         ptr_r       <= 3'd0;
         hold_cnt_r  <= 8'd0;
         gnt_idx_r   <= 3'd0;
         gnt_valid_r <= 1'b0;
         preempt_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         ptr_r       <= ptr_s;
         hold_cnt_r  <= hold_cnt_s;
         gnt_idx_r   <= gnt_idx_s;
         gnt_valid_r <= gnt_valid_s;
         preempt_r   <= preempt_s;
      end
   end

   // One-hot grant straight from registered state, no path from req.
   decoder_3_to_8 u_dec (
      .sel (gnt_idx_r),
      .en  (gnt_valid_r),
      .dec (gnt)
   );

   assign gnt_idx   = gnt_idx_r;
   assign gnt_valid = gnt_valid_r;
   assign preempt   = preempt_r;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: three instances (hold limits 4, 0 and
// the default 16) share stimulus and are compared against a per-instance
// behavioural model every cycle, plus directed constant checks.
module tb_rr_arbiter_8;

   localparam int ND = 3;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       en    = 1'b0;
   logic [7:0] req   = 8'h00;

   logic [7:0] gnt_w [ND];
   logic [2:0] idx_w [ND];
   logic       val_w [ND];
   logic       pre_w [ND];

   int n_assert = 0;
   int n_fail   = 0;

   // Model state per instance: busy owner, rotating pointer, visible cycles held.
   bit m_busy  [ND];
   int m_owner [ND];
   int m_ptr   [ND];
   int m_held  [ND];
   bit m_pre   [ND];

   always #5 clk = ~clk;

   rr_arbiter_8 #(.HOLD_MAX(4)) u_h4 (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .gnt(gnt_w[0]), .gnt_idx(idx_w[0]), .gnt_valid(val_w[0]), .preempt(pre_w[0]));

   rr_arbiter_8 #(.HOLD_MAX(0)) u_h0 (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .gnt(gnt_w[1]), .gnt_idx(idx_w[1]), .gnt_valid(val_w[1]), .preempt(pre_w[1]));

   rr_arbiter_8 u_h16 (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .gnt(gnt_w[2]), .gnt_idx(idx_w[2]), .gnt_valid(val_w[2]), .preempt(pre_w[2]));

   function automatic int hold_of(input int d);
      case (d)
         0:       return 4;
         1:       return 0;
         default: return 16;
      endcase
   endfunction

   task automatic model_reset();
      for (int d = 0; d < ND; d++) begin
         m_busy[d] = 1'b0; m_owner[d] = 0; m_ptr[d] = 0; m_held[d] = 0; m_pre[d] = 1'b0;
      end
   endtask

   // Advance the model by one rising edge using the inputs seen at that edge.
   task automatic model_tick();
      for (int d = 0; d < ND; d++) begin
         if (!rst_n) begin
            m_busy[d] = 1'b0; m_owner[d] = 0; m_ptr[d] = 0; m_held[d] = 0; m_pre[d] = 1'b0;
         end else begin
            m_pre[d] = 1'b0;
            if (!m_busy[d]) begin
               if (en && req != 8'h00) begin
                  for (int k = 0; k < 8; k++) begin
                     int i;
                     i = (m_ptr[d] + k) % 8;
                     if (req[i]) begin
                        m_owner[d] = i; m_busy[d] = 1'b1; m_held[d] = 1;
                        break;
                     end
                  end
               end
            end else if (!req[m_owner[d]]) begin
               m_busy[d] = 1'b0; m_ptr[d] = (m_owner[d] + 1) % 8;
            end else if (hold_of(d) != 0 && m_held[d] == hold_of(d)) begin
               m_busy[d] = 1'b0; m_ptr[d] = (m_owner[d] + 1) % 8; m_pre[d] = 1'b1;
            end else begin
               m_held[d] = m_held[d] + 1;
            end
         end
      end
   endtask

   task automatic check(input string tag);
      logic [7:0] eg;
      for (int d = 0; d < ND; d++) begin
         eg = m_busy[d] ? (8'h01 << m_owner[d]) : 8'h00;
         n_assert++;
         assert (gnt_w[d] === eg) else begin
            n_fail++; $error("FAIL %s u%0d gnt got %h exp %h", tag, d, gnt_w[d], eg);
         end
         n_assert++;
         assert (val_w[d] === m_busy[d]) else begin
            n_fail++; $error("FAIL %s u%0d gnt_valid got %b exp %b", tag, d, val_w[d], m_busy[d]);
         end
         n_assert++;
         assert (pre_w[d] === m_pre[d]) else begin
            n_fail++; $error("FAIL %s u%0d preempt got %b exp %b", tag, d, pre_w[d], m_pre[d]);
         end
         n_assert++;
         assert ($countones(gnt_w[d]) <= 1) else begin
            n_fail++; $error("FAIL %s u%0d onehot got %h exp at most one bit", tag, d, gnt_w[d]);
         end
         if (m_busy[d]) begin
            n_assert++;
            assert (idx_w[d] === 3'(m_owner[d])) else begin
               n_fail++; $error("FAIL %s u%0d gnt_idx got %0d exp %0d", tag, d, idx_w[d], m_owner[d]);
            end
         end
      end
   endtask

   // Directed constant check against a hand-derived value.
   task automatic expect8(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++; $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_tick();
      #1;
      check(tag);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 8'h00;
      en    = 1'b1;
      step("rst_seq");
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();

      // Reset with every request high: nothing granted until reset lifts.
      rst_n = 1'b0; en = 1'b1; req = 8'hFF;
      step("rst"); step("rst");
      expect8("rst_gnt", gnt_w[0], 8'h00);
      rst_n = 1'b1;
      step("rst_rel");
      expect8("rst_rel_gnt", gnt_w[0], 8'h01);
      expect8("rst_rel_idx", {5'd0, idx_w[0]}, 8'h00);
      req = 8'h00; step("rst_drop");

      // Rotation 0 -> 7 -> 0 with a dead cycle between grants.
      do_reset();
      req = 8'h81; step("rot"); expect8("rot_g0", gnt_w[0], 8'h01);
      step("rot"); step("rot");
      req = 8'h80; step("rot"); expect8("rot_dead1", gnt_w[0], 8'h00);
      req = 8'h81; step("rot"); expect8("rot_g7", gnt_w[0], 8'h80);
      step("rot"); step("rot");
      req = 8'h01; step("rot"); expect8("rot_dead2", gnt_w[0], 8'h00);
      req = 8'h81; step("rot"); expect8("rot_g0b", gnt_w[0], 8'h01);

      // Pointer wrap: grant 7, release, then 0 before 5.
      req = 8'h00; step("wrap");
      req = 8'h80; step("wrap"); expect8("wrap_g7", gnt_w[0], 8'h80);
      req = 8'h00; step("wrap");
      req = 8'h21; step("wrap"); expect8("wrap_g0", gnt_w[0], 8'h01);
      req = 8'h20; step("wrap"); expect8("wrap_dead", gnt_w[0], 8'h00);
      step("wrap"); expect8("wrap_g5", gnt_w[0], 8'h20);
      req = 8'h00; step("wrap");

      // Preemption after exactly four cycles; hold limit 0 never preempts.
      do_reset();
      req = 8'h06; step("pre"); expect8("pre_g1", gnt_w[0], 8'h02);
      for (int k = 0; k < 3; k++) begin
         step("pre"); expect8("pre_hold1", gnt_w[0], 8'h02);
      end
      step("pre");
      expect8("pre_drop", gnt_w[0], 8'h00);
      expect8("pre_pulse", {7'd0, pre_w[0]}, 8'h01);
      step("pre"); expect8("pre_g2", gnt_w[0], 8'h04);
      expect8("pre_pulse_end", {7'd0, pre_w[0]}, 8'h00);
      for (int k = 0; k < 24; k++) begin
         step("pre");
         expect8("pre_h0_hold", gnt_w[1], 8'h02);
      end
      req = 8'h00; step("pre");

      // Enable gating of new grants only.
      do_reset();
      en = 1'b0; req = 8'h10;
      step("en"); step("en"); expect8("en_off", gnt_w[0], 8'h00);
      en = 1'b1; step("en"); expect8("en_on", gnt_w[0], 8'h10);
      en = 1'b0; step("en"); step("en"); expect8("en_fall", gnt_w[0], 8'h10);
      req = 8'h00; step("en"); expect8("en_rel", gnt_w[0], 8'h00);
      en = 1'b1;

      // Asynchronous reset mid-grant after moving the pointer off zero.
      do_reset();
      req = 8'h02; step("arst");
      req = 8'h00; step("arst");
      req = 8'h08; step("arst"); expect8("arst_g3", gnt_w[0], 8'h08);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("arst_now");
      expect8("arst_gnt", gnt_w[0], 8'h00);
      expect8("arst_pre", {7'd0, pre_w[0]}, 8'h00);
      step("arst_hold");
      rst_n = 1'b1;
      req = 8'h09; step("arst_ptr"); expect8("arst_ptr0", gnt_w[0], 8'h01);
      req = 8'h00; step("arst");

      // Randomised traffic: bits toggle with probability 1/4, en mostly high.
      for (int n = 0; n < 2000; n++) begin
         en  = ($urandom_range(0, 9) != 0);
         req = req ^ (8'($urandom) & 8'($urandom));
         step("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Round-robin arbiter that shares one 8-way resource among eight requesters. It selects a requester with a rotating priority pointer and holds the grant until the requester releases it or a hold limit expires. It drives the grant both as a 3-bit index and as a one-hot vector. It sits between the requester-side logic and the shared datapath; the one-hot `gnt` feeds the resource's select/enable lines directly.

## Interface
- `HOLD_MAX`, default 16: maximum consecutive cycles one grant may be held; 0 disables preemption; legal range 0..255.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  arbitration enable; when low, no new grant is issued and any current grant continues.
- `req`  in  8  request vector; bit i high = requester i wants or holds the resource.
- `gnt`  out  8  one-hot grant; all zeros when nothing is granted.
- `gnt_idx`  out  3  index of the granted requester; valid only while `gnt_valid` is high.
- `gnt_valid`  out  1  high while a grant is active; equals OR of `gnt`.
- `preempt`  out  1  one-cycle pulse when a grant is removed by the hold limit.

## Operation
- **State machine:** two states, IDLE and GRANT.
- **Reset values:** state=IDLE, ptr=0, hold_cnt=0, gnt=0, gnt_idx=0, gnt_valid=0, preempt=0.
- **Reset mid-grant:** `gnt` drops asynchronously with no `preempt` pulse.
- **IDLE, `en`=1 and `req`≠0:**
  - Pick the first set bit of `req` scanning ptr, ptr+1, … 7, 0, … ptr-1 (mod 8).
  - Register the pick into `gnt_idx`, set `gnt_valid`, clear hold_cnt, go to GRANT.
- **IDLE, `en`=0 or `req`=0:** stay in IDLE with outputs zero.
- **GRANT, each cycle:** hold_cnt increments, saturating at 255.
- **GRANT, release:** if `req[gnt_idx]`=0, drop the grant, set ptr=gnt_idx+1 (3-bit wrap, 7→0), go to IDLE.
- **GRANT, preemption:** if `HOLD_MAX`≠0, `req[gnt_idx]`=1 and hold_cnt=`HOLD_MAX`-1:
  - drop the grant, set ptr=gnt_idx+1, pulse `preempt` for one cycle, go to IDLE.
  - The preempted requester may win again only after the other requesters have been scanned.
- **Release and limit on the same edge:** treat as a release; no `preempt` pulse.
- **Requests from non-granted requesters:** ignored during GRANT.
- **Other bits of `req` changing during GRANT:** no effect.
- **`en` falling during GRANT:** no effect on the current grant.
- **`gnt` generation:** one-hot decode of `gnt_idx`, forced to zero when `gnt_valid`=0.
- **Output invariant:** `gnt` has at most one bit set in every cycle.

## Timing
- **Grant latency:** `req` bit sampled high at edge N in IDLE → `gnt` high from edge N (visible in cycle N+1).
- **Release latency:** `req[gnt_idx]` sampled low at edge M → `gnt`=0 after edge M.
- **Next grant:** earliest new grant after edge M+1. There is always one dead cycle between grants (break-before-make).
- **Grant duration under preemption:** a held grant lasts exactly `HOLD_MAX` cycles; `preempt` is high during the first dead cycle.
- **Outputs:** all registered except `gnt`, which is a pure decode of registered signals. No combinational path from `req` to any output.

## Structure
- **Shared package `arb_pkg`:**
  - `N_REQ`=8, `IDX_W`=3
  - state enum {IDLE, GRANT}
  - `HOLD_W`=8 (hold_cnt width)
- **Sub-module `rr_pick_8`:** combinational rotated find-first with inputs `req[7:0]` and `ptr[2:0]`, outputs `idx[2:0]` and `any`.
- **One-hot `gnt`:** produced by an instance of the team's existing `decoder_3_to_8`, gated by `gnt_valid`.

## Test plan
- **Reset:** hold `rst_n`=0 with `req`=8'hFF → all outputs 0. Release reset → `gnt`=8'h01, `gnt_idx`=0 after the first edge.
- **Rotation:** ptr=0, `req`=8'b1000_0001 held; each requester drops its bit 3 cycles after grant → grants go 0, 7, 0 with one zero cycle between each.
- **Pointer wrap:** grant idx 7, release, then `req`=8'h21 → next grant idx 0 (ptr wrapped to 0), then idx 5.
- **Preemption:** `HOLD_MAX`=4, `req`=8'h06 held → idx 1 for exactly 4 cycles, `preempt` pulse, then idx 2 for 4 cycles. With `HOLD_MAX`=0, idx 1 is held indefinitely.
- **Enable:** `en`=0 with `req`=8'h10 → no grant. `en`=1 → `gnt`=8'h10 next edge. `en`=0 mid-grant → grant persists until release.
- **Async reset mid-grant:** assert `rst_n`=0 between edges while `gnt`=8'h08 → `gnt`=0 immediately, `preempt`=0, ptr=0 afterwards.
